register_scoreboard: RTL and testbench
======================================

Name: register_scoreboard

Overview:
- Tracks outstanding register writes for the pipelined core. It sits directly upstream of the register file read ports, between decode/issue and the register file.
- Decode asks each cycle whether an instruction may issue. The block stalls on RAW hazards and on pending-write saturation.
- It releases entries when writeback drives the register file write port, or when a squashed instruction is killed.
- Per-register pending counters allow several in-flight writes to the same register, which is needed for late-returning loads.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is never tracked.
- CNTW, 2, width of each pending counter; MAXPEND = 2**CNTW - 1 outstanding writes per register.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- iss_valid  in  1  decode presents an instruction.
- iss_rs  in  5  source register A.
- iss_rs_used  in  1  source A is read.
- iss_rt  in  5  source register B.
- iss_rt_used  in  1  source B is read.
- iss_rd  in  5  destination register.
- iss_wen  in  1  instruction writes iss_rd.
- iss_stall  out  1  combinational; instruction must hold.
- iss_fire  out  1  combinational; iss_valid & ~iss_stall.
- wb_valid  in  1  writeback writes wb_sel this cycle (same signal as the register file wen).
- wb_sel  in  5  register written.
- kill_valid  in  1  a squashed in-flight writer is cancelled.
- kill_sel  in  5  its destination.
- busy  out  NREGS  busy[i] = (count[i] != 0); bit 0 always 0.
- empty  out  1  all counts zero; used for halt/drain.
- err  out  1  sticky underflow flag.
- stall_cycles  out  32  see Optional Feature.

Behaviour:
- Reset (RST high at posedge) clears all counts, err and stall_cycles. Reset dominates all other inputs in that cycle.
- While RST is high: iss_stall=1, iss_fire=0, busy=0, empty=1.
- Effective count, eff[i] = count[i] - (wb_valid & wb_sel==i) - (kill_valid & kill_sel==i), floored at 0. The register file writes on the falling edge, so a read in the same cycle as the write sees new data. A same-cycle release therefore unblocks issue.
- Stall conditions (any one stalls):
  - iss_rs_used & iss_rs!=0 & eff[iss_rs]!=0.
  - iss_rt_used & iss_rt!=0 & eff[iss_rt]!=0.
  - iss_wen & iss_rd!=0 & eff[iss_rd]==MAXPEND.
- iss_stall is 0 when iss_valid=0.
- Next count: count[i] + inc - dec.
  - inc = iss_fire & iss_wen & iss_rd==i & i!=0.
  - dec = number of matching wb/kill releases (0..2).
  - Issue and release of the same register in the same cycle leaves the count unchanged (net).
- Underflow: a decrement larger than count[i] clamps the count to 0 and sets err=1. err is cleared only by RST.
- Releases targeting register 0 are ignored and never set err.
- Latency: issue increments are visible on busy/empty one cycle after iss_fire.
- Releases affect iss_stall in the same cycle, and busy/empty the next cycle.
- iss_stall is purely combinational from state and current inputs; it has no registered path.

Optional Feature:
- Macro SCOREBOARD_STATS_EN.
- Defined: stall_cycles increments on each cycle with iss_valid & iss_stall & ~RST. It saturates at 32'hFFFF_FFFF and is cleared by RST.
- Undefined: the counter logic is not compiled; stall_cycles is tied to 0.

Decomposition:
- Shared package (cpu_types_pkg) holds:
  - SB_CNTW constant (2).
  - sb_cnt_t = logic [SB_CNTW-1:0].
  - The existing regbits_t for register indices.
- Sub-module sb_counter, instantiated once per register 1..NREGS-1:
  - Inputs: inc, dec[1:0].
  - Outputs: count, eff, underflow.
  - The top level does decode of iss_rd/wb_sel/kill_sel, the stall OR-tree, err, empty and stats.

Test Plan:
- Basic RAW:
  - Issue rd=5 with wen; next cycle issue rs=5 used → iss_stall=1.
  - wb_valid, wb_sel=5 that cycle → iss_stall=0 the same cycle; busy[5]=0 the next cycle.
- Saturation:
  - Issue rd=7 three times → busy[7]=1.
  - Fourth issue with iss_wen, rd=7 → stall.
  - One wb_sel=7 release → fourth issue fires; count stays 3.
- Register 0:
  - Issue rd=0 wen, then rs=0/rt=0 used → never stalls; busy=0, empty=1.
  - wb_sel=0 → err stays 0.
- Kill + wb on one register:
  - count[9]=2, then kill_sel=9 and wb_sel=9 the same cycle → count[9]=0 next cycle.
  - Extra wb_sel=9 → err=1 and stays 1 until RST.
- Simultaneous issue/release:
  - count[3]=1; issue rd=3 wen while wb_sel=3 → count[3]=1; empty=0.
- Reset mid-operation:
  - Several counts nonzero, RST high one cycle → busy=0, empty=1, err=0, iss_stall=1 during RST, stall_cycles=0.
  - With SCOREBOARD_STATS_EN: 4 stalled cycles after reset → stall_cycles=4.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared core types: register indices, scoreboard counter width and the
// release-decode helper used by the register scoreboard.
package cpu_types_pkg;

    localparam int REGW    = 5;
    localparam int SB_CNTW = 2;

    typedef logic [REGW-1:0]    regbits_t;
    typedef logic [SB_CNTW-1:0] sb_cnt_t;

    // Number of releases (writeback and/or kill) aimed at register idx this cycle.
    function automatic logic [1:0] sb_rel_count(
        input logic     wb_v,
        input regbits_t wb_s,
        input logic     kill_v,
        input regbits_t kill_s,
        input regbits_t idx
    );
        return {1'b0, (wb_v && (wb_s == idx))} + {1'b0, (kill_v && (kill_s == idx))};
    endfunction

endpackage

// File: rtl/register_scoreboard_if.sv
// Issue / writeback / kill bundle between decode and the register scoreboard.
// master = decode/pipeline side, slave = scoreboard.
interface register_scoreboard_if
    import cpu_types_pkg::*;
#(
    parameter int NREGS = 32
);
    logic             iss_valid;
    regbits_t         iss_rs;
    logic             iss_rs_used;
    regbits_t         iss_rt;
    logic             iss_rt_used;
    regbits_t         iss_rd;
    logic             iss_wen;
    logic             iss_stall;
    logic             iss_fire;
    logic             wb_valid;
    regbits_t         wb_sel;
    logic             kill_valid;
    regbits_t         kill_sel;
    logic [NREGS-1:0] busy;
    logic             empty;
    logic             err;
    logic [31:0]      stall_cycles;

    modport master (
        output iss_valid, iss_rs, iss_rs_used, iss_rt, iss_rt_used, iss_rd, iss_wen,
        output wb_valid, wb_sel, kill_valid, kill_sel,
        input  iss_stall, iss_fire, busy, empty, err, stall_cycles
    );

    modport slave (
        input  iss_valid, iss_rs, iss_rs_used, iss_rt, iss_rt_used, iss_rd, iss_wen,
        input  wb_valid, wb_sel, kill_valid, kill_sel,
        output iss_stall, iss_fire, busy, empty, err, stall_cycles
    );

endinterface

// File: rtl/register_scoreboard_sb_counter.sv
// Pending-write counter for one architectural register: one increment per
// issued writer, up to two releases per cycle, clamped at zero on underflow.
module sb_counter
    import cpu_types_pkg::*;
#(
    parameter int CNTW = SB_CNTW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            inc,
    input  logic [1:0]      dec,
    output logic [CNTW-1:0] count,
    output logic [CNTW-1:0] eff,
    output logic            underflow
);

    typedef logic [CNTW:0] ext_t;

    logic [CNTW-1:0] r_count;
    ext_t            w_dec;
    ext_t            w_sum;
    ext_t            w_next;
    ext_t            w_eff;

    // Issue can only fire when eff < MAXPEND, so w_next always fits in CNTW bits.
    always_comb begin
        w_dec     = ext_t'(dec);
        w_sum     = ext_t'(r_count) + ext_t'(inc);
        w_eff     = ext_t'(r_count) - w_dec;
        underflow = (w_dec > ext_t'(r_count));
        eff       = underflow ? '0 : w_eff[CNTW-1:0];
        w_next    = (w_sum >= w_dec) ? (w_sum - w_dec) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every counter
    // samples the same pre-edge values regardless of evaluation order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= '0;
        end else begin
            r_count <= w_next[CNTW-1:0];
        end
    end

    assign count = r_count;

endmodule

// File: rtl/register_scoreboard.sv
// Register scoreboard: per-register pending-write counters, combinational
// RAW/saturation stall, sticky underflow error. SCOREBOARD_STATS_EN adds a stall counter.
module register_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNTW  = SB_CNTW
) (
    input  logic                  CLK,
    input  logic                  RST,
    register_scoreboard_if.slave  sb
);

    localparam logic [CNTW-1:0] MAXPEND = '1;

    logic [CNTW-1:0] w_count     [NREGS];
    logic [CNTW-1:0] w_eff       [NREGS];
    logic            w_underflow [NREGS];
    logic            w_rs_hit;
    logic            w_rt_hit;
    logic            w_rd_sat;
    logic            w_hazard;
    logic            w_any_busy;
    logic            w_any_uflow;
    logic            r_err;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign w_count[i]     = '0;
            assign w_eff[i]       = '0;
            assign w_underflow[i] = 1'b0;
        end else begin : g_cnt
            logic       w_inc;
            logic [1:0] w_dec;

            assign w_inc = sb.iss_fire & sb.iss_wen & (sb.iss_rd == regbits_t'(i));
            assign w_dec = sb_rel_count(sb.wb_valid, sb.wb_sel, sb.kill_valid,
                                        sb.kill_sel, regbits_t'(i));

            sb_counter #(.CNTW(CNTW)) u_cnt (
                .CLK       (CLK),
                .RST       (RST),
                .inc       (w_inc),
                .dec       (w_dec),
                .count     (w_count[i]),
                .eff       (w_eff[i]),
                .underflow (w_underflow[i])
            );
        end
    end

    // Hazards look at the effective count so a same-cycle writeback unblocks issue.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        w_rd_sat = 1'b0;
        if (sb.iss_rs_used && (sb.iss_rs != '0)) begin
            w_rs_hit = (w_eff[sb.iss_rs] != '0);
        end
        if (sb.iss_rt_used && (sb.iss_rt != '0)) begin
            w_rt_hit = (w_eff[sb.iss_rt] != '0);
        end
        if (sb.iss_wen && (sb.iss_rd != '0)) begin
            w_rd_sat = (w_eff[sb.iss_rd] == MAXPEND);
        end
        w_hazard = w_rs_hit | w_rt_hit | w_rd_sat;
    end

    assign sb.iss_stall = RST | (sb.iss_valid & w_hazard);
    assign sb.iss_fire  = sb.iss_valid & ~sb.iss_stall;

    always_comb begin
        w_any_busy  = 1'b0;
        w_any_uflow = 1'b0;
        sb.busy     = '0;
        for (int i = 1; i < NREGS; i++) begin
            sb.busy[i]  = ~RST & (w_count[i] != '0);
            w_any_busy  = w_any_busy | (w_count[i] != '0);
            w_any_uflow = w_any_uflow | w_underflow[i];
        end
    end

    assign sb.empty = RST | ~w_any_busy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_any_uflow) begin
            r_err <= 1'b1;
        end
    end

    assign sb.err = r_err;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cycles <= '0;
        end else if (sb.iss_valid && sb.iss_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign sb.stall_cycles = r_stall_cycles;
`else
    assign sb.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard: a behavioural model predicts
// stall/fire each cycle and pushes expected post-edge state into a queue.
module tb_register_scoreboard;
    import cpu_types_pkg::*;

    localparam int NREGS = 32;
    localparam int MAXP  = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    register_scoreboard_if #(.NREGS(NREGS)) sb ();

    register_scoreboard #(.NREGS(NREGS), .CNTW(SB_CNTW)) dut (
        .CLK (CLK),
        .RST (RST),
        .sb  (sb)
    );

    typedef struct {
        logic [NREGS-1:0] busy;
        logic             empty;
        logic             err;
        logic [31:0]      stalls;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          m_cnt[NREGS];
    bit          m_err    = 1'b0;
    logic [31:0] m_stalls = '0;

    function automatic int m_rel(input int r);
        return int'(sb.wb_valid && (sb.wb_sel == regbits_t'(r))) +
               int'(sb.kill_valid && (sb.kill_sel == regbits_t'(r)));
    endfunction

    function automatic int m_eff(input int r);
        int e;
        e = m_cnt[r] - m_rel(r);
        return (e < 0) ? 0 : e;
    endfunction

    function automatic bit m_stall();
        if (RST) return 1'b1;
        if (!sb.iss_valid) return 1'b0;
        if (sb.iss_rs_used && sb.iss_rs != 0 && m_eff(int'(sb.iss_rs)) != 0) return 1'b1;
        if (sb.iss_rt_used && sb.iss_rt != 0 && m_eff(int'(sb.iss_rt)) != 0) return 1'b1;
        if (sb.iss_wen && sb.iss_rd != 0 && m_eff(int'(sb.iss_rd)) == MAXP) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_issue(input bit v, input int rs, input bit rsu, input int rt,
                             input bit rtu, input int rd, input bit wen);
        sb.iss_valid   = v;
        sb.iss_rs      = regbits_t'(rs);
        sb.iss_rs_used = rsu;
        sb.iss_rt      = regbits_t'(rt);
        sb.iss_rt_used = rtu;
        sb.iss_rd      = regbits_t'(rd);
        sb.iss_wen     = wen;
    endtask

    task automatic set_rel(input bit wv, input int ws, input bit kv, input int ks);
        sb.wb_valid   = wv;
        sb.wb_sel     = regbits_t'(ws);
        sb.kill_valid = kv;
        sb.kill_sel   = regbits_t'(ks);
    endtask

    task automatic idle();
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_rel(0, 0, 0, 0);
    endtask

    // One clock: compare combinational outputs, advance the model, then compare post-edge state.
    task automatic tick(input string tag);
        bit   exp_stall;
        bit   exp_fire;
        exp_t e;
        exp_t got;
        int   n;
        #1;
        exp_stall = m_stall();
        exp_fire  = sb.iss_valid && !exp_stall;
        checks++;
        if (sb.iss_stall !== exp_stall) begin
            failures++;
            $display("FAIL %s/iss_stall got=%b want=%b", tag, sb.iss_stall, exp_stall);
        end
        checks++;
        if (sb.iss_fire !== exp_fire) begin
            failures++;
            $display("FAIL %s/iss_fire got=%b want=%b", tag, sb.iss_fire, exp_fire);
        end
        if (RST) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
            m_err    = 1'b0;
            m_stalls = '0;
        end else begin
`ifdef SCOREBOARD_STATS_EN
            if (sb.iss_valid && exp_stall && m_stalls != 32'hFFFF_FFFF) m_stalls++;
`endif
            for (int r = 1; r < NREGS; r++) begin
                n = m_cnt[r] + int'(exp_fire && sb.iss_wen && sb.iss_rd == regbits_t'(r)) - m_rel(r);
                if (m_rel(r) > m_cnt[r]) m_err = 1'b1;
                m_cnt[r] = (n < 0) ? 0 : n;
            end
        end
        e.busy  = '0;
        e.empty = 1'b1;
        for (int r = 1; r < NREGS; r++) begin
            e.busy[r] = (m_cnt[r] != 0);
            if (m_cnt[r] != 0) e.empty = 1'b0;
        end
        e.err    = m_err;
        e.stalls = m_stalls;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        got = exp_q.pop_front();
        checks++;
        if (sb.busy !== got.busy) begin
            failures++;
            $display("FAIL %s/busy got=%h want=%h", tag, sb.busy, got.busy);
        end
        checks++;
        if (sb.empty !== got.empty) begin
            failures++;
            $display("FAIL %s/empty got=%b want=%b", tag, sb.empty, got.empty);
        end
        checks++;
        if (sb.err !== got.err) begin
            failures++;
            $display("FAIL %s/err got=%b want=%b", tag, sb.err, got.err);
        end
        checks++;
        if (sb.stall_cycles !== got.stalls) begin
            failures++;
            $display("FAIL %s/stall_cycles got=%0d want=%0d", tag, sb.stall_cycles, got.stalls);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        set_issue(1, 5, 1, 6, 1, 7, 1);
        set_rel(0, 0, 0, 0);
        #1;
        checks++;
        if (sb.iss_stall !== 1'b1 || sb.iss_fire !== 1'b0) begin
            failures++;
            $display("FAIL reset/stall_fire got=%b%b want=10", sb.iss_stall, sb.iss_fire);
        end
        checks++;
        if (sb.busy !== '0 || sb.empty !== 1'b1) begin
            failures++;
            $display("FAIL reset/busy_empty got=%h,%b want=0,1", sb.busy, sb.empty);
        end
        tick("reset0");
        tick("reset1");
        RST = 1'b0;
        idle();
        tick("reset_idle");
    endtask

    task automatic test_raw();
        set_issue(1, 0, 0, 0, 0, 5, 1);
        tick("raw_wr5");
        checks++;
        if (sb.busy[5] !== 1'b1) begin
            failures++;
            $display("FAIL raw/busy5_set got=%b want=1", sb.busy[5]);
        end
        set_issue(1, 5, 1, 0, 0, 0, 0);
        #1;
        checks++;
        if (sb.iss_stall !== 1'b1) begin
            failures++;
            $display("FAIL raw/stall got=%b want=1", sb.iss_stall);
        end
        tick("raw_stalled");
        set_rel(1, 5, 0, 0);
        #1;
        checks++;
        if (sb.iss_stall !== 1'b0 || sb.iss_fire !== 1'b1) begin
            failures++;
            $display("FAIL raw/wb_bypass stall_fire got=%b%b want=01", sb.iss_stall, sb.iss_fire);
        end
        tick("raw_release");
        checks++;
        if (sb.busy[5] !== 1'b0) begin
            failures++;
            $display("FAIL raw/busy5_clear got=%b want=0", sb.busy[5]);
        end
        idle();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < MAXP; k++) begin
            set_issue(1, 0, 0, 0, 0, 7, 1);
            tick("sat_fill");
        end
        checks++;
        if (sb.busy[7] !== 1'b1) begin
            failures++;
            $display("FAIL sat/busy7 got=%b want=1", sb.busy[7]);
        end
        #1;
        checks++;
        if (sb.iss_stall !== 1'b1) begin
            failures++;
            $display("FAIL sat/fourth_stall got=%b want=1", sb.iss_stall);
        end
        tick("sat_blocked");
        set_rel(1, 7, 0, 0);
        #1;
        checks++;
        if (sb.iss_fire !== 1'b1) begin
            failures++;
            $display("FAIL sat/fourth_fire got=%b want=1", sb.iss_fire);
        end
        tick("sat_swap");
        set_rel(0, 0, 0, 0);
        #1;
        checks++;
        if (sb.iss_stall !== 1'b1) begin
            failures++;
            $display("FAIL sat/still_full got=%b want=1", sb.iss_stall);
        end
        tick("sat_full_again");
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_rel(1, 7, 0, 0);
        for (int k = 0; k < MAXP; k++) tick("sat_drain");
        idle();
    endtask

    task automatic test_reg0();
        set_issue(1, 0, 1, 0, 1, 0, 1);
        #1;
        checks++;
        if (sb.iss_stall !== 1'b0) begin
            failures++;
            $display("FAIL reg0/stall got=%b want=0", sb.iss_stall);
        end
        tick("reg0_issue");
        checks++;
        if (sb.busy !== '0 || sb.empty !== 1'b1) begin
            failures++;
            $display("FAIL reg0/busy_empty got=%h,%b want=0,1", sb.busy, sb.empty);
        end
        set_rel(1, 0, 1, 0);
        tick("reg0_release");
        checks++;
        if (sb.err !== 1'b0) begin
            failures++;
            $display("FAIL reg0/err got=%b want=0", sb.err);
        end
        idle();
    endtask

    task automatic test_kill_wb();
        set_issue(1, 0, 0, 0, 0, 9, 1);
        tick("kw_wr9a");
        tick("kw_wr9b");
        set_issue(0, 0, 0, 0, 0, 0, 0);
        set_rel(1, 9, 1, 9);
        tick("kw_double");
        checks++;
        if (sb.busy[9] !== 1'b0 || sb.err !== 1'b0) begin
            failures++;
            $display("FAIL kw/double_release busy9,err got=%b,%b want=0,0", sb.busy[9], sb.err);
        end
        set_rel(1, 9, 0, 0);
        tick("kw_underflow");
        idle();
        tick("kw_idle0");
        tick("kw_idle1");
        checks++;
        if (sb.err !== 1'b1) begin
            failures++;
            $display("FAIL kw/err_sticky got=%b want=1", sb.err);
        end
    endtask

    task automatic test_simultaneous();
        set_issue(1, 0, 0, 0, 0, 3, 1);
        tick("sim_wr3");
        set_rel(1, 3, 0, 0);
        #1;
        checks++;
        if (sb.iss_fire !== 1'b1) begin
            failures++;
            $display("FAIL sim/fire got=%b want=1", sb.iss_fire);
        end
        tick("sim_net");
        checks++;
        if (sb.busy[3] !== 1'b1 || sb.empty !== 1'b0) begin
            failures++;
            $display("FAIL sim/busy3_empty got=%b,%b want=1,0", sb.busy[3], sb.empty);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        set_issue(1, 0, 0, 0, 0, 10, 1);
        tick("mid_wr10");
        set_issue(1, 0, 0, 0, 0, 11, 1);
        tick("mid_wr11");
        RST = 1'b1;
        set_issue(1, 10, 1, 11, 1, 12, 1);
        #1;
        checks++;
        if (sb.iss_stall !== 1'b1) begin
            failures++;
            $display("FAIL mid/stall_in_reset got=%b want=1", sb.iss_stall);
        end
        tick("mid_reset");
        RST = 1'b0;
        idle();
        #1;
        checks++;
        if (sb.busy !== '0 || sb.empty !== 1'b1 || sb.err !== 1'b0 || sb.stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL mid/after_reset got busy=%h empty=%b err=%b stalls=%0d want 0,1,0,0",
                     sb.busy, sb.empty, sb.err, sb.stall_cycles);
        end
    endtask

    task automatic test_stats();
        logic [31:0] want;
`ifdef SCOREBOARD_STATS_EN
        want = 32'd4;
`else
        want = 32'd0;
`endif
        set_issue(1, 0, 0, 0, 0, 4, 1);
        tick("st_wr4");
        set_issue(1, 4, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick("st_stall");
        idle();
        #1;
        checks++;
        if (sb.stall_cycles !== want) begin
            failures++;
            $display("FAIL stats/stall_cycles got=%0d want=%0d", sb.stall_cycles, want);
        end
        set_rel(1, 4, 0, 0);
        tick("st_drain");
        idle();
    endtask

    initial begin
        foreach (m_cnt[r]) m_cnt[r] = 0;
        idle();
        @(posedge CLK);
        #1;
        test_reset();
        test_raw();
        test_saturation();
        test_reg0();
        test_kill_wb();
        test_simultaneous();
        test_reset_mid();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
